// File: rtl/block_cache_if.sv
// Lookup, response, chunk-read and counter signals of block_cache. A BlockPos is
// packed {x, y, z}, each a two's-complement COORD_W-bit coordinate.
interface block_cache_if #(
    parameter int COORD_W     = 8,
    parameter int TYPE_W      = 8,
    parameter int COUNT_WIDTH = 16
);
    localparam int POS_W = 3 * COORD_W;

    // Handshake: a request transfers on a rising clk_in edge where req_valid and
    // req_ready are both 1. resp_valid is a one-cycle pulse that cannot be stalled.
    // chunk_valid qualifies chunk_out for the address currently on chunk_addr.
    logic [POS_W-1:0]       req_addr;
    logic                   req_valid;
    logic                   req_ready;
    logic                   flush_in;
    logic [TYPE_W-1:0]      resp_type;
    logic                   resp_valid;
    logic [POS_W-1:0]       chunk_addr;
    logic                   chunk_read_enable;
    logic [TYPE_W-1:0]      chunk_out;
    logic                   chunk_valid;
    logic [COUNT_WIDTH-1:0] hit_count;
    logic [COUNT_WIDTH-1:0] miss_count;

    modport slave (
        input  req_addr, req_valid, flush_in, chunk_out, chunk_valid,
        output req_ready, resp_type, resp_valid, chunk_addr, chunk_read_enable,
               hit_count, miss_count
    );

    modport master (
        output req_addr, req_valid, flush_in, chunk_out, chunk_valid,
        input  req_ready, resp_type, resp_valid, chunk_addr, chunk_read_enable,
               hit_count, miss_count
    );
endinterface

// File: rtl/block_cache.sv
// Direct-mapped flop cache of block types in front of the chunk ROM, with
// saturating hit/miss counters.
module block_cache #(
    parameter int INDEX_BITS  = 2,
    parameter int COUNT_WIDTH = 16,
    parameter int COORD_W     = 8,
    parameter int TYPE_W      = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    block_cache_if.slave bus,
    output logic [1:0]  o_state_dbg
);
    localparam int POS_W  = 3 * COORD_W;
    localparam int IDX_W  = 3 * INDEX_BITS;
    localparam int LINES  = 2 ** IDX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [LINES-1:0]       r_valid;
    logic [POS_W-1:0]       r_tag  [LINES];
    logic [TYPE_W-1:0]      r_data [LINES];
    logic [POS_W-1:0]       r_addr_q;
    logic [TYPE_W-1:0]      r_resp_q;
    logic [COUNT_WIDTH-1:0] r_hit_cnt;
    logic [COUNT_WIDTH-1:0] r_miss_cnt;

    logic [IDX_W-1:0]       w_index;
    logic                   w_hit;
    logic                   w_req_ready;
    logic                   w_resp_valid;
    logic [TYPE_W-1:0]      w_resp_type;
    logic                   w_fill_write;

    assign w_index = {r_addr_q[2*COORD_W +: INDEX_BITS],
                      r_addr_q[COORD_W   +: INDEX_BITS],
                      r_addr_q[0         +: INDEX_BITS]};
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == r_addr_q);

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_type  = '0;
        w_fill_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = !bus.flush_in && !rst_in;
                if (!bus.flush_in && bus.req_valid) w_next_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_resp_valid = 1'b1;
                    w_resp_type  = r_data[w_index];
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.chunk_valid) begin
                    w_fill_write = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                w_resp_type  = r_resp_q;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_addr_q   <= '0;
            r_resp_q   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE) begin
                if (bus.flush_in) r_valid <= '0;
                else if (bus.req_valid) r_addr_q <= bus.req_addr;
            end
            if (r_state == S_LOOKUP) begin
                if (w_hit) begin
                    if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                end else if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
            if (w_fill_write) begin
                r_valid[w_index] <= 1'b1;
                r_resp_q         <= bus.chunk_out;
            end
        end
    end

    // Tag and data carry no reset; the valid bits alone decide whether they are used.
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_fill_write) begin
            r_tag[w_index]  <= r_addr_q;
            r_data[w_index] <= bus.chunk_out;
        end
    end

    assign bus.req_ready         = w_req_ready;
    assign bus.resp_valid        = w_resp_valid;
    assign bus.resp_type         = w_resp_type;
    assign bus.chunk_addr        = r_addr_q;
    assign bus.chunk_read_enable = (r_state == S_FILL);
    assign bus.hit_count         = r_hit_cnt;
    assign bus.miss_count        = r_miss_cnt;
    assign o_state_dbg           = r_state;
endmodule
